// File: rtl/la_uart_dump.sv
// la_uart_dump: streams a window of the capture RAM out through uart_tx as a
// framed packet: A5 5A LEN_H LEN_L payload[0..length-1] [CSUM].
// Optional feature macro: LA_DUMP_CSUM_EN appends a modulo-256 payload checksum.
// The FSM is split into a state register, next-state logic and output decode.
// Datapath registers use a separate next-value process.
module la_uart_dump #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [7:0]        mem_rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SYNC0,
        S_SYNC1,
        S_LENH,
        S_LENL,
        S_RD,
        S_LATCH,
        S_SEND,
        S_FIN
`ifdef LA_DUMP_CSUM_EN
        ,
        S_CSUM
`endif
    } state_t;

    // State entered once the last payload byte (or LEN_L for an empty frame) has gone.
`ifdef LA_DUMP_CSUM_EN
    localparam state_t S_TAIL = S_CSUM;
`else
    localparam state_t S_TAIL = S_FIN;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [7:0]        data_q, data_d;
`ifdef LA_DUMP_CSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic [15:0] len16;
    logic        xfer;
    logic        accept;

    assign len16  = 16'(len_q);
    assign xfer   = tx_valid && tx_ready;
    // abort in IDLE blocks a simultaneous start
    assign accept = (state_q == S_IDLE) && start && !abort;

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_SYNC0;
            S_SYNC0: if (xfer) state_d = S_SYNC1;
            S_SYNC1: if (xfer) state_d = S_LENH;
            S_LENH:  if (xfer) state_d = S_LENL;
            S_LENL:  if (xfer) state_d = (rem_q != '0) ? S_RD : S_TAIL;
            S_RD:    state_d = S_LATCH;
            S_LATCH: state_d = S_SEND;
            // rem_q still counts the byte being sent, so 1 means it was the last
            S_SEND:  if (xfer) state_d = (rem_q != (ADDR_W+1)'(1)) ? S_RD : S_TAIL;
`ifdef LA_DUMP_CSUM_EN
            S_CSUM:  if (xfer) state_d = S_FIN;
`endif
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
        end
    end

    // Datapath registers: address, remaining count, length, payload byte, checksum
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            rem_q  <= '0;
            len_q  <= '0;
            data_q <= '0;
`ifdef LA_DUMP_CSUM_EN
            csum_q <= '0;
`endif
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
            len_q  <= len_d;
            data_q <= data_d;
`ifdef LA_DUMP_CSUM_EN
            csum_q <= csum_d;
`endif
        end
    end

    // Datapath next values: load on accept, capture RAM data, advance on payload transfer
    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        len_d  = len_q;
        data_d = data_q;
`ifdef LA_DUMP_CSUM_EN
        csum_d = csum_q;
`endif
        if (accept) begin
            addr_d = start_addr;
            rem_d  = length;
            len_d  = length;
`ifdef LA_DUMP_CSUM_EN
            csum_d = '0;
`endif
        end
        if (state_q == S_LATCH) begin
            data_d = mem_rd_data;
        end
        if (state_q == S_SEND && xfer) begin
            // address width makes the wrap to 0 at the buffer end implicit
            addr_d = addr_q + ADDR_W'(1);
            rem_d  = rem_q - (ADDR_W+1)'(1);
`ifdef LA_DUMP_CSUM_EN
            csum_d = csum_q + data_q;
`endif
        end
    end

    // Output decode: everything is a function of registered state, so all outputs are 0 in IDLE
    always_comb begin
        busy        = (state_q != S_IDLE);
        done        = 1'b0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        tx_data     = 8'h00;
        tx_valid    = 1'b0;
        case (state_q)
            S_SYNC0: begin tx_valid = 1'b1; tx_data = 8'hA5;        end
            S_SYNC1: begin tx_valid = 1'b1; tx_data = 8'h5A;        end
            S_LENH:  begin tx_valid = 1'b1; tx_data = len16[15:8];  end
            S_LENL:  begin tx_valid = 1'b1; tx_data = len16[7:0];   end
            S_RD:    begin mem_rd_en = 1'b1; mem_rd_addr = addr_q;  end
            S_SEND:  begin tx_valid = 1'b1; tx_data = data_q;       end
`ifdef LA_DUMP_CSUM_EN
            S_CSUM:  begin tx_valid = 1'b1; tx_data = csum_q;       end
`endif
            S_FIN:   done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_la_uart_dump.sv
// Bench for la_uart_dump: 1-cycle RAM model, ready responder (always-ready,
// random-stall or held low), scoreboard queues for bytes and read addresses.
module tb_la_uart_dump;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW:0]   length;
    logic          abort;
    logic          busy;
    logic          done;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [7:0]    mem_rd_data;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;

    always #5 clk = ~clk;

    la_uart_dump #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .mem_rd_en  (mem_rd_en),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready)
    );

    logic [7:0] mem [DEPTH];

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    logic [7:0]    exp_q[$];
    logic [AW-1:0] exp_addr_q[$];
    int n_cmp    = 0;
    int n_err    = 0;
    int byte_cnt = 0;
    int rd_cnt   = 0;
    int done_cnt = 0;
    int mode     = 0;
    logic hold   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ready responder: changes 1 time unit after the active edge
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (hold)           tx_ready = 1'b0;
            else if (mode == 0) tx_ready = 1'b1;
            else                tx_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // monitor: sample on the falling edge, score bytes, reads and done pulses
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (tx_valid && tx_ready) begin
                    byte_cnt++;
                    if (exp_q.size() == 0) chk("extra_byte", exp_q.size(), 1);
                    else                   chk("tx_byte", tx_data, exp_q.pop_front());
                end
                if (mem_rd_en) begin
                    rd_cnt++;
                    if (exp_addr_q.size() == 0) chk("extra_read", exp_addr_q.size(), 1);
                    else                        chk("rd_addr", mem_rd_addr, exp_addr_q.pop_front());
                end
                if (done) done_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load_frame(input int a, input int len);
        logic [7:0]  c;
        logic [15:0] l16;
        int          ad;
        c   = 8'h00;
        l16 = 16'(len);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(l16[15:8]);
        exp_q.push_back(l16[7:0]);
        for (int i = 0; i < len; i++) begin
            ad = (a + i) % DEPTH;
            exp_addr_q.push_back(AW'(ad));
            exp_q.push_back(mem[ad]);
            c = c + mem[ad];
        end
`ifdef LA_DUMP_CSUM_EN
        exp_q.push_back(c);
`endif
    endtask

    task automatic send_start(input int a, input int len);
        load_frame(a, len);
        start      = 1'b1;
        start_addr = AW'(a);
        length     = (AW+1)'(len);
        tick();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_valid", tx_valid, 1);
        chk("start_sync0", tx_data, 8'hA5);
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 20000; k++) begin
            if (done) break;
            tick();
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_at_done"}, busy, 1);
        tick();
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_bytes_left"}, exp_q.size(), 0);
        chk({tag, "_reads_left"}, exp_addr_q.size(), 0);
    endtask

    task automatic wait_bytes(input int n);
        for (int k = 0; k < 20000; k++) begin
            if (byte_cnt >= n) break;
            tick();
        end
        chk("wait_bytes", (byte_cnt >= n), 1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rd_en"}, mem_rd_en, 0);
        chk({tag, "_rd_addr"}, mem_rd_addr, 0);
        chk({tag, "_tx_valid"}, tx_valid, 0);
        chk({tag, "_tx_data"}, tx_data, 0);
    endtask

    initial begin
        int d0, b0, r0;
        logic [7:0] held;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        start_addr = '0; length = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i * 37 + (i >> 4));
        mem[16'h010] = 8'hA5; mem[16'h011] = 8'h5A;
        mem[16'h012] = 8'h00; mem[16'h013] = 8'hFF;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // basic frame, always ready
        d0 = done_cnt;
        send_start(16'h010, 4);
        wait_done("basic");
        chk("basic_done_pulses", done_cnt - d0, 1);

        // wrap across buffer end, random stalls
        mode = 1;
        send_start(16'h3FE, 4);
        wait_done("wrap");

        // empty payload: no reads at all
        r0 = rd_cnt;
        send_start(16'h055, 0);
        wait_done("len0");
        chk("len0_no_reads", rd_cnt - r0, 0);

        // full-buffer length
        b0 = byte_cnt;
        send_start(16'h123, 1024);
        wait_done("len1024");
`ifdef LA_DUMP_CSUM_EN
        chk("len1024_total", byte_cnt - b0, 1029);
`else
        chk("len1024_total", byte_cnt - b0, 1028);
`endif

        // backpressure mid-payload
        mode = 0;
        b0 = byte_cnt;
        send_start(16'h040, 8);
        wait_bytes(b0 + 6);
        for (int k = 0; k < 10; k++) begin
            if (tx_valid) break;
            tick();
        end
        hold = 1'b1;
        tx_ready = 1'b0;
        held = tx_data;
        r0 = rd_cnt;
        chk("bp_valid_start", tx_valid, 1);
        repeat (50) begin
            tick();
            chk("bp_valid_held", tx_valid, 1);
            chk("bp_data_held", tx_data, held);
        end
        chk("bp_no_reads", rd_cnt - r0, 0);
        hold = 1'b0;
        tx_ready = 1'b1;
        wait_done("bp");

        // abort after payload byte 2, with an ignored start while busy
        d0 = done_cnt;
        b0 = byte_cnt;
        send_start(16'h100, 8);
        start = 1'b1; start_addr = AW'(16'h200); length = (AW+1)'(3);
        tick();
        start = 1'b0;
        chk("busy_start_ignored", busy, 1);
        wait_bytes(b0 + 6);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid", tx_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_rd_en", mem_rd_en, 0);
        exp_q.delete();
        exp_addr_q.delete();
        repeat (5) tick();
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_no_bytes", byte_cnt - b0, 6);

        // start and abort together in IDLE: abort wins
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", busy, 0);
        tick();
        chk("start_abort_valid", tx_valid, 0);

        // fresh frame after abort
        mode = 1;
        send_start(16'h100, 8);
        wait_done("restart");

        // reset during LEN_H
        mode = 0;
        b0 = byte_cnt;
        send_start(16'h300, 5);
        wait_bytes(b0 + 2);
        chk("lenh_state_data", tx_data, 8'h00);
        rst = 1'b1;
        tick();
        check_all_zero("midrst");
        rst = 1'b0;
        exp_q.delete();
        exp_addr_q.delete();
        tick();
        d0 = done_cnt;
        send_start(16'h300, 5);
        wait_done("after_rst");
        chk("after_rst_done_pulses", done_cnt - d0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/la_uart_dump.md
# la_uart_dump

Controller that streams a window of the logic analyzer's capture RAM out through the `uart_tx` byte transmitter as a framed packet. A start pulse supplies the start address and sample count. The block then reads the RAM one byte at a time, wraps addresses at the buffer end, and drives `uart_tx`'s `tx_data`/`tx_valid`/`tx_ready` handshake. It sits between the capture buffer and `uart_tx`, and is the only master of `uart_tx`.

## Interface
- `ADDR_W`, 10: capture RAM address width, 1..15.
- `clk`  in  1: system clock.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: single-cycle request. Accepted only when `busy`=0; ignored otherwise.
- `start_addr`  in  ADDR_W: first sample address. Sampled on the accepting cycle.
- `length`  in  ADDR_W+1: number of samples, 0..2^ADDR_W. Sampled on the accepting cycle.
- `abort`  in  1: terminates the frame and returns the block to IDLE.
- `busy`  out  1: high from the cycle after acceptance until the block is back in IDLE.
- `done`  out  1: one-cycle pulse after the last frame byte is accepted.
- `mem_rd_en`  out  1: read strobe to capture RAM.
- `mem_rd_addr`  out  ADDR_W: read address.
- `mem_rd_data`  in  8: read data, valid exactly one cycle after `mem_rd_en`.
- `tx_data`  out  8: byte presented to `uart_tx`.
- `tx_valid`  out  1: byte valid.
- `tx_ready`  in  1: `uart_tx` can accept a byte.

## Operation
- Frame layout: 0xA5, 0x5A, LEN_H, LEN_L, payload[0..length-1], then an optional CSUM byte.
  - LEN is `length` zero-extended to 16 bits.
  - Payload byte i comes from address (start_addr + i) mod 2^ADDR_W.
- A byte transfers on any cycle with `tx_valid` && `tx_ready`.
- While `tx_valid`=1 and the byte has not transferred, `tx_data` is held stable.
- States and transitions:
  - IDLE: on `start`, go to SYNC0.
  - SYNC0: go to SYNC1 on transfer.
  - SYNC1: go to LEN_H on transfer.
  - LEN_H: go to LEN_L on transfer.
  - LEN_L: on transfer, go to RD if remaining>0; otherwise go to CSUM, or to FIN when CSUM is compiled out.
  - RD: assert `mem_rd_en` at the current address, then go to LATCH.
  - LATCH: load `mem_rd_data` into `tx_data`, set `tx_valid`, then go to SEND.
  - SEND: on transfer, increment the address, decrement remaining, and go to RD if remaining>0, else to CSUM or FIN.
  - CSUM: go to FIN on transfer.
  - FIN: pulse `done`, then go to IDLE.
- Exactly one RAM read is issued per payload byte. No reads are issued during backpressure.
- The address counter wraps from 2^ADDR_W-1 to 0.
- `abort` in any non-IDLE state:
  - Next cycle: `tx_valid`=0, `mem_rd_en`=0, state=IDLE, no `done`.
  - If a transfer happens on the same cycle as `abort`, that byte counts as sent; the abort still takes effect.
- `start` and `abort` asserted together in IDLE: `abort` wins and `start` is ignored.
- Reset values: all outputs 0, state IDLE, counters 0.
  - `rst` asserted mid-frame forces these values on the next edge.
  - `uart_tx` may still be shifting out the last accepted byte; this block does not track that.

## Timing
- Start accepted in cycle S: `busy`=1 and `tx_valid`=1 with 0xA5 from S+1.
- Header and CSUM bytes: the next byte is presented in the cycle after the previous transfer. This applies to 0x5A, LEN_H, LEN_L, and CSUM.
- Payload: previous byte transfers in cycle T.
  - T+1: `mem_rd_en`=1.
  - T+2: data latched.
  - T+3 onward: `tx_valid`=1.
- Last byte transfers in cycle L: `done`=1 in L+1; `busy`=0 from L+2.
- `start` is accepted again from L+2.

## Configuration
- `LA_DUMP_CSUM_EN` defined:
  - A CSUM byte follows the payload. CSUM = 8-bit modulo-256 sum of the payload bytes only (not header or LEN).
  - CSUM is 0x00 when length=0.
  - The accumulator is cleared on acceptance of `start`.
- `LA_DUMP_CSUM_EN` undefined: no CSUM state, no accumulator; the frame ends after the last payload byte (or after LEN_L when length=0).

## Test plan
Every scenario uses a 1-cycle-latency RAM model and `tx_ready` driven by either `uart_tx` or a random-stall responder.
- Basic frame: mem[0x010..0x013]=A5,5A,00,FF; start_addr=0x010, length=4.
  - Required bytes: A5 5A 00 04 A5 5A 00 FF FE (FE only with CSUM).
  - One `done` pulse; read addresses exactly 0x010..0x013.
- Wrap: start_addr=0x3FE, length=4.
  - Read addresses 0x3FE, 0x3FF, 0x000, 0x001 in order; LEN bytes 00 04.
- Boundary lengths:
  - length=0: bytes A5 5A 00 00 (+00 with CSUM), and no `mem_rd_en` at all.
  - length=1024: LEN bytes 04 00, and 1028 (+1) bytes total.
- Backpressure: hold `tx_ready`=0 for 50 cycles while `tx_valid`=1 mid-payload.
  - `tx_data` stays constant and no extra `mem_rd_en` occurs.
  - The byte stream is unchanged versus the no-stall run.
- Abort and re-start:
  - `abort` after payload byte 2 of length=8: `tx_valid`=0 next cycle, `busy` drops, no `done`.
  - `start` pulsed while busy is ignored.
  - A fresh `start` afterwards yields a complete correct frame.
- Reset mid-frame: assert `rst` during LEN_H.
  - All outputs are 0 on the next edge.
  - A new start produces a full frame beginning 0xA5.
